pid_controller_mc: RTL

- Multi-channel, parametrised successor to the single-loop PID controller.
- Runs NUM_CH independent PID loops through one shared, time-multiplexed multiply/accumulate datapath.
- Adds per-channel gains, a fixed-point gain format, integrator clamping, output saturation limits, per-channel valid strobes and overrun detection.
- Sits between sensor-sampling logic and actuator drivers in the control subsystem.

---
 rtl/pid_mc_pkg.sv | 41 ++++
 rtl/pid_prescaler.sv | 24 ++
 rtl/pid_controller_mc.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pid_mc_pkg.sv
// Shared types and helpers for the multi-channel PID controller.
package pid_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        MAC  = 2'd2,
        SAT  = 2'd3
    } pid_state_t;

    // Helpers operate on a wide signed container so any configured width fits.
    localparam int SAT_W = 64;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input logic signed [SAT_W-1:0] lo,
        input logic signed [SAT_W-1:0] hi
    );
        // An inverted window collapses onto the lower bound.
        if (lo > hi)    return lo;
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

    function automatic logic signed [SAT_W-1:0] clamp_sym(
        input logic signed [SAT_W-1:0] value,
        input logic [SAT_W-1:0]        limit
    );
        logic signed [SAT_W-1:0] lim;
        lim = signed'(limit);
        if (value > lim)  return lim;
        if (value < -lim) return -lim;
        return value;
    endfunction

endpackage

// File: rtl/pid_prescaler.sv
// Free-running sweep prescaler: counts 0..period and flags the terminal count.
module pid_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] period,
    output logic        tick
);

    logic [15:0] count;

    assign tick = (count == period);

    // Period is used live; lowering it below the count lets the counter roll over 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/pid_controller_mc.sv
// NUM_CH PID loops sharing one time-multiplexed MAC datapath (ERR -> MAC -> SAT per channel).
// Define PID_COND_INTEGRATION_EN for conditional-integration anti-windup.
module pid_controller_mc
    import pid_mc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40,
    parameter int NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [15:0]                clk_prescaler,
    input  logic [NUM_CH*DATA_W-1:0]   setpoint,
    input  logic [NUM_CH*DATA_W-1:0]   feedback,
    input  logic [NUM_CH*GAIN_W-1:0]   Kp,
    input  logic [NUM_CH*GAIN_W-1:0]   Ki,
    input  logic [NUM_CH*GAIN_W-1:0]   Kd,
    input  logic [ACC_W-2:0]           int_limit,
    input  logic [DATA_W-1:0]          out_min,
    input  logic [DATA_W-1:0]          out_max,
    output logic [NUM_CH*DATA_W-1:0]   control_signal,
    output logic [NUM_CH-1:0]          ctrl_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int EW   = DATA_W + 1;
    localparam int DW   = DATA_W + 2;
    localparam int PW   = GAIN_W + DW;
    localparam int CH_W = ch_idx_w(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    pid_state_t state, state_next;
    logic [CH_W-1:0] ch;
    logic tick, start, last_ch;

    logic signed [DATA_W-1:0] sp_s [NUM_CH];
    logic signed [DATA_W-1:0] fb_s [NUM_CH];
    logic signed [GAIN_W-1:0] kp_s [NUM_CH];
    logic signed [GAIN_W-1:0] ki_s [NUM_CH];
    logic signed [GAIN_W-1:0] kd_s [NUM_CH];
    logic [ACC_W-2:0]         lim_s;
    logic signed [DATA_W-1:0] min_s, max_s;

    logic signed [ACC_W-1:0]  integ  [NUM_CH];
    logic signed [EW-1:0]     e_prev [NUM_CH];
    logic signed [DATA_W-1:0] y_r    [NUM_CH];

    logic signed [EW-1:0]     e_r, e_calc;
    logic signed [DW-1:0]     d_r, d_calc;
    logic signed [PW-1:0]     p_prod, i_prod, d_prod;
    logic signed [ACC_W-1:0]  i_sum, i_new, sum_calc, inew_r, sum_r, shifted;
    logic signed [DATA_W-1:0] y;
    logic                     hold;

    pid_prescaler u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .period (clk_prescaler),
        .tick   (tick)
    );

    assign busy    = (state != IDLE);
    assign overrun = tick && busy;
    assign start   = (state == IDLE) && tick && enable;
    assign last_ch = (ch == LAST_CH);

    assign e_calc = EW'(sp_s[ch]) - EW'(fb_s[ch]);
    assign d_calc = DW'(e_calc) - DW'(e_prev[ch]);

    assign p_prod   = PW'(kp_s[ch]) * PW'(e_r);
    assign i_prod   = PW'(ki_s[ch]) * PW'(e_r);
    assign d_prod   = PW'(kd_s[ch]) * PW'(d_r);
    assign i_sum    = integ[ch] + ACC_W'(i_prod);
    assign i_new    = ACC_W'(clamp_sym(SAT_W'(i_sum), SAT_W'(lim_s)));
    assign sum_calc = ACC_W'(p_prod) + i_new + ACC_W'(d_prod);

    assign shifted = sum_r >>> FRAC_W;
    assign y       = DATA_W'(sat_signed(SAT_W'(shifted), SAT_W'(min_s), SAT_W'(max_s)));

`ifdef PID_COND_INTEGRATION_EN
    // Freeze the integrator while the output is pinned and the error keeps pushing outward.
    assign hold = ((shifted > ACC_W'(max_s)) && (e_r > 0)) ||
                  ((shifted < ACC_W'(min_s)) && (e_r < 0));
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ERR;
            ERR:     state_next = MAC;
            MAC:     state_next = SAT;
            SAT:     state_next = last_ch ? IDLE : ERR;
            default: state_next = IDLE;
        endcase
    end

    // Inputs are captured once per sweep so mid-sweep changes cannot mix channels' data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch         <= '0;
            ctrl_valid <= '0;
            e_r        <= '0;
            d_r        <= '0;
            inew_r     <= '0;
            sum_r      <= '0;
            lim_s      <= '0;
            min_s      <= '0;
            max_s      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sp_s[i]   <= '0;
                fb_s[i]   <= '0;
                kp_s[i]   <= '0;
                ki_s[i]   <= '0;
                kd_s[i]   <= '0;
                integ[i]  <= '0;
                e_prev[i] <= '0;
                y_r[i]    <= '0;
            end
        end else begin
            ctrl_valid <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ch    <= '0;
                        lim_s <= int_limit;
                        min_s <= out_min;
                        max_s <= out_max;
                        for (int i = 0; i < NUM_CH; i++) begin
                            sp_s[i] <= setpoint[i*DATA_W +: DATA_W];
                            fb_s[i] <= feedback[i*DATA_W +: DATA_W];
                            kp_s[i] <= Kp[i*GAIN_W +: GAIN_W];
                            ki_s[i] <= Ki[i*GAIN_W +: GAIN_W];
                            kd_s[i] <= Kd[i*GAIN_W +: GAIN_W];
                        end
                    end
                end
                ERR: begin
                    e_r <= e_calc;
                    d_r <= d_calc;
                end
                MAC: begin
                    inew_r <= i_new;
                    sum_r  <= sum_calc;
                end
                SAT: begin
                    y_r[ch]        <= y;
                    e_prev[ch]     <= e_r;
                    ctrl_valid[ch] <= 1'b1;
                    if (!hold) integ[ch] <= inew_r;
                    if (!last_ch) ch <= ch + CH_W'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign control_signal[g*DATA_W +: DATA_W] = y_r[g];
    end

endmodule
